// File: rtl/pmem_write_buffer.sv
// Line-granular write buffer between the core's pmem bus and physical memory.
// Define PMEM_WB_FORWARD_EN to serve read hits directly from the buffer.
module pmem_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_read,
    input  logic         up_write,
    input  logic [15:0]  up_address,
    input  logic [127:0] up_wdata,
    output logic [127:0] up_rdata,
    output logic         up_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         wb_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

`ifdef PMEM_WB_FORWARD_EN
    localparam bit FORWARD = 1'b1;
`else
    localparam bit FORWARD = 1'b0;
`endif

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [11:0]      tag_mem  [DEPTH];
    logic [127:0]     data_mem [DEPTH];
    logic [127:0]     up_rdata_reg;
    logic [127:0]     pmem_wdata_reg;
    logic [15:0]      pmem_address_reg;

    logic [DEPTH-1:0] hit_vec;
    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic             full;
    logic             unused_bits;

    assign unused_bits = ^up_address[3:0];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign hit_vec[gi] = valid_reg[gi] && (tag_mem[gi] == up_address[15:4]);
        end
    endgenerate

    // Coalescing guarantees at most one entry per line, so a plain encoder suffices.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) hit_idx = PTR_W'(i);
        end
    end

    assign hit  = |hit_vec;
    assign full = (count_reg == CNT_W'(DEPTH));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            head_reg         <= '0;
            tail_reg         <= '0;
            valid_reg        <= '0;
            up_rdata_reg     <= '0;
            pmem_address_reg <= '0;
            pmem_wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (up_read) begin
                        if (hit && FORWARD) begin
                            up_rdata_reg <= data_mem[hit_idx];
                            state_reg    <= RESP;
                        end else if (hit) begin
                            // Drain in order until the matching line reaches memory.
                            pmem_address_reg <= {tag_mem[head_reg], 4'h0};
                            pmem_wdata_reg   <= data_mem[head_reg];
                            state_reg        <= WR;
                        end else begin
                            pmem_address_reg <= {up_address[15:4], 4'h0};
                            state_reg        <= RD;
                        end
                    end else if (up_write) begin
                        if (hit) begin
                            data_mem[hit_idx] <= up_wdata;
                            state_reg         <= RESP;
                        end else if (!full) begin
                            tag_mem[tail_reg]   <= up_address[15:4];
                            data_mem[tail_reg]  <= up_wdata;
                            valid_reg[tail_reg] <= 1'b1;
                            tail_reg            <= ptr_inc(tail_reg);
                            count_reg           <= count_reg + CNT_W'(1);
                            state_reg           <= RESP;
                        end else begin
                            pmem_address_reg <= {tag_mem[head_reg], 4'h0};
                            pmem_wdata_reg   <= data_mem[head_reg];
                            state_reg        <= WR;
                        end
                    end else if (count_reg != '0) begin
                        pmem_address_reg <= {tag_mem[head_reg], 4'h0};
                        pmem_wdata_reg   <= data_mem[head_reg];
                        state_reg        <= WR;
                    end
                end
                RD: begin
                    if (pmem_resp) begin
                        up_rdata_reg <= pmem_rdata;
                        state_reg    <= RESP;
                    end
                end
                WR: begin
                    if (pmem_resp) begin
                        valid_reg[head_reg] <= 1'b0;
                        head_reg            <= ptr_inc(head_reg);
                        count_reg           <= count_reg - CNT_W'(1);
                        state_reg           <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign up_resp      = (state_reg == RESP);
    assign pmem_read    = (state_reg == RD);
    assign pmem_write   = (state_reg == WR);
    assign up_rdata     = up_rdata_reg;
    assign pmem_address = pmem_address_reg;
    assign pmem_wdata   = pmem_wdata_reg;
    assign wb_empty     = (count_reg == '0) && (state_reg != WR);

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer (DEPTH=2); follows PMEM_WB_FORWARD_EN if defined.
module tb_pmem_write_buffer;
    logic         clk = 1'b0;
    logic         reset;
    logic         up_read;
    logic         up_write;
    logic [15:0]  up_address;
    logic [127:0] up_wdata;
    logic [127:0] up_rdata;
    logic         up_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         wb_empty;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] DATA_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DATA_B = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    localparam logic [127:0] DATA_C = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
    localparam logic [127:0] DATA_D = 128'hDDDD_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DATA_E = 128'hEEEE_9999_8888_7777_6666_5555_4444_3333;

    pmem_write_buffer #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .up_read(up_read), .up_write(up_write), .up_address(up_address),
        .up_wdata(up_wdata), .up_rdata(up_rdata), .up_resp(up_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From IDLE with entries buffered: expect one drain of the given line, then answer it.
    task automatic drain_one(input string tag, input logic [15:0] addr, input logic [127:0] data);
        tick();
        chk({tag, "_pmem_write"}, 128'(pmem_write), 128'(1'b1));
        chk({tag, "_pmem_read"}, 128'(pmem_read), 128'(1'b0));
        chk({tag, "_addr"}, 128'(pmem_address), 128'(addr));
        chk({tag, "_wdata"}, pmem_wdata, data);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk({tag, "_write_done"}, 128'(pmem_write), 128'(1'b0));
        $display("drain %s addr=%h data=%h", tag, addr, data);
    endtask

    initial begin
        reset = 1'b1; up_read = 1'b0; up_write = 1'b0; up_address = '0;
        up_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        tick(); tick();
        chk("rst_up_resp", 128'(up_resp), 128'(1'b0));
        chk("rst_up_rdata", up_rdata, 128'h0);
        chk("rst_pmem_read", 128'(pmem_read), 128'(1'b0));
        chk("rst_pmem_write", 128'(pmem_write), 128'(1'b0));
        chk("rst_pmem_address", 128'(pmem_address), 128'h0);
        chk("rst_pmem_wdata", pmem_wdata, 128'h0);
        chk("rst_wb_empty", 128'(wb_empty), 128'(1'b1));
        reset = 1'b0;
        $display("reset released");

        // Single write absorbed, then drained when idle.
        up_write = 1'b1; up_address = 16'h1230; up_wdata = DATA_A;
        tick();
        chk("w1_resp", 128'(up_resp), 128'(1'b1));
        chk("w1_no_pmem", 128'(pmem_write), 128'(1'b0));
        chk("w1_not_empty", 128'(wb_empty), 128'(1'b0));
        up_write = 1'b0;
        tick();
        chk("w1_resp_pulse", 128'(up_resp), 128'(1'b0));
        $display("write 1230 accepted");
        drain_one("w1", 16'h1230, DATA_A);
        chk("w1_empty", 128'(wb_empty), 128'(1'b1));

        // Fill both entries, then a third write forces a drain of the oldest.
        up_write = 1'b1; up_address = 16'h0010; up_wdata = DATA_A;
        tick();
        chk("f1_resp", 128'(up_resp), 128'(1'b1));
        up_address = 16'h0020; up_wdata = DATA_B;
        tick();
        tick();
        chk("f2_resp", 128'(up_resp), 128'(1'b1));
        up_address = 16'h0030; up_wdata = DATA_C;
        tick();
        tick();
        chk("f3_drain_write", 128'(pmem_write), 128'(1'b1));
        chk("f3_drain_addr", 128'(pmem_address), 128'h0010);
        chk("f3_drain_data", pmem_wdata, DATA_A);
        chk("f3_no_resp", 128'(up_resp), 128'(1'b0));
        tick(); tick();
        chk("f3_held_write", 128'(pmem_write), 128'(1'b1));
        chk("f3_held_no_resp", 128'(up_resp), 128'(1'b0));
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("f3_after_pop_no_resp", 128'(up_resp), 128'(1'b0));
        chk("f3_after_pop_idle", 128'(pmem_write), 128'(1'b0));
        tick();
        chk("f3_resp", 128'(up_resp), 128'(1'b1));
        up_write = 1'b0;
        tick();
        $display("full-buffer write completed after head drain");
        drain_one("f_0020", 16'h0020, DATA_B);
        drain_one("f_0030", 16'h0030, DATA_C);
        chk("f_empty", 128'(wb_empty), 128'(1'b1));

        // Two writes to the same line coalesce into one entry.
        up_write = 1'b1; up_address = 16'h0040; up_wdata = DATA_A;
        tick();
        chk("c1_resp", 128'(up_resp), 128'(1'b1));
        up_address = 16'h0048; up_wdata = DATA_B;
        tick();
        tick();
        chk("c2_resp", 128'(up_resp), 128'(1'b1));
        up_write = 1'b0;
        tick();
        drain_one("coalesce", 16'h0040, DATA_B);
        chk("c_empty", 128'(wb_empty), 128'(1'b1));
        tick();
        chk("c_no_second_drain", 128'(pmem_write), 128'(1'b0));
        $display("coalesced write drained once");

        // Read of a buffered line.
        up_write = 1'b1; up_address = 16'h0050; up_wdata = DATA_C;
        tick();
        chk("h_wr_resp", 128'(up_resp), 128'(1'b1));
        up_write = 1'b0; up_read = 1'b1;
        tick();
        tick();
`ifdef PMEM_WB_FORWARD_EN
        chk("h_fwd_resp", 128'(up_resp), 128'(1'b1));
        chk("h_fwd_rdata", up_rdata, DATA_C);
        chk("h_fwd_no_read", 128'(pmem_read), 128'(1'b0));
        up_read = 1'b0;
        tick();
        drain_one("h_fwd", 16'h0050, DATA_C);
`else
        chk("h_nf_write", 128'(pmem_write), 128'(1'b1));
        chk("h_nf_no_read", 128'(pmem_read), 128'(1'b0));
        chk("h_nf_waddr", 128'(pmem_address), 128'h0050);
        chk("h_nf_wdata", pmem_wdata, DATA_C);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
        chk("h_nf_read", 128'(pmem_read), 128'(1'b1));
        chk("h_nf_read_no_write", 128'(pmem_write), 128'(1'b0));
        chk("h_nf_raddr", 128'(pmem_address), 128'h0050);
        pmem_rdata = DATA_C; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("h_nf_resp", 128'(up_resp), 128'(1'b1));
        chk("h_nf_rdata", up_rdata, DATA_C);
        up_read = 1'b0;
        tick();
`endif
        chk("h_empty", 128'(wb_empty), 128'(1'b1));
        $display("read of buffered line 0050 served");

        // Read miss bypasses the pending drain.
        up_write = 1'b1; up_address = 16'h0060; up_wdata = DATA_D;
        tick();
        chk("m_wr_resp", 128'(up_resp), 128'(1'b1));
        up_write = 1'b0; up_read = 1'b1; up_address = 16'h0070;
        tick();
        tick();
        chk("m_read", 128'(pmem_read), 128'(1'b1));
        chk("m_no_write", 128'(pmem_write), 128'(1'b0));
        chk("m_raddr", 128'(pmem_address), 128'h0070);
        pmem_rdata = DATA_E; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        chk("m_resp", 128'(up_resp), 128'(1'b1));
        chk("m_rdata", up_rdata, DATA_E);
        up_read = 1'b0;
        tick();
        $display("read miss 0070 served before drain");

        // Reset during a drain discards the buffer.
        tick();
        chk("r_drain_active", 128'(pmem_write), 128'(1'b1));
        chk("r_drain_addr", 128'(pmem_address), 128'h0060);
        reset = 1'b1;
        tick();
        chk("r_pmem_write", 128'(pmem_write), 128'(1'b0));
        chk("r_pmem_read", 128'(pmem_read), 128'(1'b0));
        chk("r_up_resp", 128'(up_resp), 128'(1'b0));
        chk("r_up_rdata", up_rdata, 128'h0);
        chk("r_pmem_address", 128'(pmem_address), 128'h0);
        chk("r_pmem_wdata", pmem_wdata, 128'h0);
        chk("r_wb_empty", 128'(wb_empty), 128'(1'b1));
        reset = 1'b0;
        tick(); tick();
        chk("r_no_redrain", 128'(pmem_write), 128'(1'b0));
        chk("r_still_empty", 128'(wb_empty), 128'(1'b1));
        $display("reset mid-drain cleared buffer");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pmem_write_buffer.md
# pmem_write_buffer

Line-granular write buffer between the core's physical-memory port (the arbitrated `pmem_*` bus out of the LC-3b pipeline top) and physical memory. Dirty-line writebacks are absorbed in one cycle and drained to memory when the bus is idle, so demand read misses are not held behind writebacks. Read requests to a line still held in the buffer are checked against it so memory is never read stale.

## Interface
Parameters:
- `DEPTH`, 2: number of 128-bit line entries (≥1); occupancy counter is `$clog2(DEPTH+1)` bits.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `up_read`  in  1  line read request from core side; held until `up_resp`.
- `up_write`  in  1  line write request from core side; held until `up_resp`.
- `up_address`  in  16  byte address; line address is `[15:4]`, `[3:0]` ignored.
- `up_wdata`  in  128  write line (lc3b_c_block).
- `up_rdata`  out  128  read line, registered; valid in the `up_resp` cycle of a read.
- `up_resp`  out  1  one-cycle completion pulse.
- `pmem_read`  out  1  memory read strobe, held until `pmem_resp`.
- `pmem_write`  out  1  memory write strobe, held until `pmem_resp`.
- `pmem_address`  out  16  line address to memory, `[3:0]` driven 0.
- `pmem_wdata`  out  128  line written to memory.
- `pmem_rdata`  in  128  line from memory, valid when `pmem_resp`.
- `pmem_resp`  in  1  memory completion, one cycle.
- `wb_empty`  out  1  high when occupancy is 0 and no drain is in flight.

## Operation
- FIFO of `DEPTH` entries {line address [15:4], data[127:0]}, head/tail pointers wrap modulo `DEPTH`, plus occupancy `count`.
- FSM states: IDLE, RD, WR, RESP.
- IDLE priority, highest first:
  - `up_read`, then `up_write`, then drain.
  - `up_read` and `up_write` together is illegal; read is served and the write is ignored that cycle.
- `up_read` in IDLE:
  - Line matches an entry: with forwarding, copy the entry to `up_rdata` and go to RESP.
  - No match: go to RD. `pmem_read` is high with `pmem_address = {up_address[15:4],4'h0}`.
- RD: on `pmem_resp`, capture `pmem_rdata` into `up_rdata` and go to RESP.
- `up_write` in IDLE:
  - Line matches an entry: coalesce by overwriting that entry's data. `count` is unchanged, even when full. Go to RESP.
  - No match and not full: push at tail, `count+1`, go to RESP.
  - No match and full: go to WR to drain the head. The write stays pending and is re-evaluated in IDLE afterwards.
- No request and `count>0` in IDLE: go to WR.
- WR:
  - `pmem_write` high with head address and data.
  - On `pmem_resp`: pop head, `count-1`, return to IDLE.
  - A started drain always completes; upstream requests wait.
- RESP: `up_resp`=1 for exactly this cycle, then IDLE.
- Lines never have duplicate entries, because of coalescing; at most one entry matches.
- Reset mid-transaction: FSM goes to IDLE, `count`/pointers clear, buffered data is discarded, and strobes drop the next cycle.

## Timing
- Reset values: `up_resp`=0, `up_rdata`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `wb_empty`=1.
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- Requests are sampled only in IDLE. The requester must drop or replace its request in the cycle after `up_resp`.
- Write accept, or read hit, sampled at cycle t: `up_resp` at t+1. Minimum 2-cycle turnaround per request.
- Read miss at t: `pmem_read` from t+1 through the `pmem_resp` cycle p; `up_resp` and `up_rdata` at p+1.
- Drain starting at t: `pmem_write` from t+1 through p; `count` decrements at p+1.
- `pmem_read` and `pmem_write` are never high together.

## Configuration
- `PMEM_WB_FORWARD_EN` defined: a read hit in the buffer is served from the buffer with 1-cycle latency.
- Not defined: a read that matches any entry goes to WR and drains entries, in order, until the matching line has been written. It then re-evaluates as a miss and reads memory.
- In both cases, returned data equals the most recent write to that line.

## Test plan
- Reset, then `up_write` to 0x1230 with data A, and no pmem activity → `up_resp` 1 cycle later. Then, idle, `pmem_write` to 0x1230 with data A; after `pmem_resp`, `wb_empty`=1.
- Two writes (0x0010, 0x0020) with DEPTH=2 and `pmem_resp` withheld, then a third write to 0x0030 → drain of 0x0010 first. The third `up_resp` comes only after that `pmem_resp`.
- Write 0x0040 with data A, then write 0x0048 with data B → single entry (coalesced); drain writes B once.
- Buffered 0x0050 with data C, then `up_read` 0x0050:
  - forward build → `up_rdata`=C next cycle, no `pmem_read`;
  - non-forward build → `pmem_write` 0x0050, then `pmem_read`.
- Buffer holds 0x0060, then `up_read` 0x0070 → `pmem_read` issued before any `pmem_write`; `up_rdata`=`pmem_rdata`.
- `reset` asserted while `pmem_write` is high → next cycle all outputs are at reset values and `wb_empty`=1.
